// File: rtl/bus_arbiter_rr8_if.sv
// Bus-side signal bundle for bus_arbiter_rr8.
//   Req[7:0]     per-master request (Req[i] selects Mux8to1 input In(i+1))
//   Grant[7:0]   one-hot registered grant, zero when the bus is unowned
//   Sel[2:0]     encoded owner index feeding Mux8to1.Sel
//   BusValid     high while a master owns the bus
//   HoldExpired  one-cycle pulse when ownership is revoked by the hold limit
// Modports: master = requesters' view, slave = arbiter's view.
interface bus_arbiter_rr8_if;
  logic [7:0] Req;
  logic [7:0] Grant;
  logic [2:0] Sel;
  logic       BusValid;
  logic       HoldExpired;

  modport master (output Req, input Grant, Sel, BusValid, HoldExpired);
  modport slave  (input Req, output Grant, Sel, BusValid, HoldExpired);
endinterface

// File: rtl/bus_arbiter_rr8.sv
// Round-robin arbiter for the 8-master bus ahead of the SDRAM controller.
// Grants one requester at a time and drives the 3-bit select of the
// downstream 8:1 data mux. All outputs are registered.
// Ports:
//   Clk    rising-edge clock
//   Reset  synchronous, active-high
//   bus    bus_arbiter_rr8_if.slave (Req in; Grant, Sel, BusValid,
//          HoldExpired out)
// Parameters:
//   MAX_HOLD    max cycles of Grant high per ownership (2..255), only
//               meaningful with ARB_TIMEOUT_EN
//   TURNAROUND  idle TURN cycles between owners (1..7)
// Build option:
//   ARB_TIMEOUT_EN  when defined, ownership is revoked after MAX_HOLD cycles
//                   and HoldExpired pulses; otherwise HoldExpired is tied 0.
module bus_arbiter_rr8 #(
  parameter int unsigned MAX_HOLD   = 16,
  parameter int unsigned TURNAROUND = 1
) (
  input logic             Clk,
  input logic             Reset,
  bus_arbiter_rr8_if.slave bus
);

  if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_max_hold
    $error("bus_arbiter_rr8: MAX_HOLD out of range 2..255");
  end
  if (TURNAROUND < 1 || TURNAROUND > 7) begin : g_bad_turnaround
    $error("bus_arbiter_rr8: TURNAROUND out of range 1..7");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN  = 2'd1,
    TURN = 2'd2
  } state_t;

  state_t     state, state_nx;
  logic [7:0] grant, grant_nx;
  logic [2:0] sel, sel_nx;
  logic [2:0] last, last_nx;
  logic [2:0] turn_cnt, turn_cnt_nx;
  logic [2:0] winner;
  logic       winner_ok;
  logic [2:0] idx;
  logic       limit_hit;

`ifdef ARB_TIMEOUT_EN
  logic [7:0] hold_cnt, hold_cnt_nx;
  logic       hold_exp, hold_exp_nx;

  assign limit_hit = (hold_cnt == 8'(MAX_HOLD - 1));
`else
  assign limit_hit = 1'b0;
`endif

  // Rotating priority: search starts just after the last owner, so a master
  // that just released is considered only after every other requester.
  always_comb begin
    winner    = '0;
    winner_ok = 1'b0;
    idx       = '0;
    for (int unsigned k = 1; k <= 8; k++) begin
      idx = 3'(last + 3'(k));
      if (!winner_ok && bus.Req[idx]) begin
        winner    = idx;
        winner_ok = 1'b1;
      end
    end
  end

  always_comb begin
    state_nx    = state;
    grant_nx    = grant;
    sel_nx      = sel;
    last_nx     = last;
    turn_cnt_nx = turn_cnt;
`ifdef ARB_TIMEOUT_EN
    hold_cnt_nx = hold_cnt;
    hold_exp_nx = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (winner_ok) begin
          grant_nx = 8'b1 << winner;
          sel_nx   = winner;
          state_nx = OWN;
`ifdef ARB_TIMEOUT_EN
          hold_cnt_nx = '0;
`endif
        end
      end
      OWN: begin
`ifdef ARB_TIMEOUT_EN
        if (hold_cnt != '1) hold_cnt_nx = hold_cnt + 8'd1;
`endif
        // Sel is left on the old owner so the mux output stays stable.
        if (!bus.Req[sel] || limit_hit) begin
          grant_nx    = '0;
          last_nx     = sel;
          turn_cnt_nx = '0;
          state_nx    = TURN;
`ifdef ARB_TIMEOUT_EN
          // A voluntary drop coinciding with the limit is a normal release.
          hold_exp_nx = bus.Req[sel];
`endif
        end
      end
      TURN: begin
        if (turn_cnt == 3'(TURNAROUND - 1)) state_nx = IDLE;
        else                                turn_cnt_nx = turn_cnt + 3'd1;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state    <= IDLE;
      grant    <= '0;
      sel      <= '0;
      last     <= 3'd7;
      turn_cnt <= '0;
`ifdef ARB_TIMEOUT_EN
      hold_cnt <= '0;
      hold_exp <= 1'b0;
`endif
    end else begin
      state    <= state_nx;
      grant    <= grant_nx;
      sel      <= sel_nx;
      last     <= last_nx;
      turn_cnt <= turn_cnt_nx;
`ifdef ARB_TIMEOUT_EN
      hold_cnt <= hold_cnt_nx;
      hold_exp <= hold_exp_nx;
`endif
    end
  end

  assign bus.Grant    = grant;
  assign bus.Sel      = sel;
  assign bus.BusValid = |grant;
`ifdef ARB_TIMEOUT_EN
  assign bus.HoldExpired = hold_exp;
`else
  assign bus.HoldExpired = 1'b0;
`endif

endmodule

// File: tb/tb_bus_arbiter_rr8.sv
module tb_bus_arbiter_rr8;
  localparam int MH = 16;
  localparam int TA = 1;
`ifdef ARB_TIMEOUT_EN
  localparam bit TIMEOUT = 1'b1;
`else
  localparam bit TIMEOUT = 1'b0;
`endif

  logic Clk;
  logic Reset;
  bus_arbiter_rr8_if bus();

  bus_arbiter_rr8 #(.MAX_HOLD(MH), .TURNAROUND(TA)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int total  = 0;
  int passed = 0;

  // Reference model: edge counter, current owner (-1 = none), the edge from
  // which a new grant may be issued, and the edge at which ownership began.
  int m_n       = 0;
  int m_owner   = -1;
  int m_last    = 7;
  int m_sel     = 0;
  int m_idle_at = 0;
  int m_start   = 0;
  bit m_hexp    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, m_n);
  endtask

  task automatic model_step(input bit r, input logic [7:0] q);
    bit found;
    int c;
    m_n++;
    if (r) begin
      m_owner = -1; m_last = 7; m_sel = 0; m_hexp = 0; m_idle_at = m_n + 1;
    end else if (m_owner >= 0) begin
      m_hexp = 0;
      if (!q[m_owner]) begin
        m_last = m_owner; m_owner = -1; m_idle_at = m_n + TA + 1;
      end else if (TIMEOUT && (m_n - m_start) == MH) begin
        m_hexp = 1; m_last = m_owner; m_owner = -1; m_idle_at = m_n + TA + 1;
      end
    end else begin
      m_hexp = 0;
      if (m_n >= m_idle_at && q != 8'h00) begin
        found = 0;
        for (int d = 1; d <= 8; d++) begin
          c = (m_last + d) % 8;
          if (!found && q[c]) begin
            found = 1; m_owner = c; m_sel = c; m_start = m_n;
          end
        end
      end
    end
  endtask

  task automatic drive_edge(input bit r, input logic [7:0] q);
    Reset = r;
    bus.Req = q;
    @(posedge Clk);
    model_step(r, q);
    #1;
  endtask

  task automatic check_model();
    logic [7:0] eg;
    eg = (m_owner >= 0) ? (8'b1 << m_owner) : 8'h00;
    check("grant", bus.Grant, eg);
    check("sel", bus.Sel, m_sel);
    check("busvalid", bus.BusValid, (m_owner >= 0) ? 1 : 0);
    check("holdexpired", bus.HoldExpired, m_hexp);
  endtask

  task automatic tick(input bit r, input logic [7:0] q);
    drive_edge(r, q);
    check_model();
  endtask

  typedef struct {
    bit         rst;
    logic [7:0] req;
    logic [7:0] g;
    logic [2:0] s;
    bit         bv;
  } vec_t;

  vec_t tbl[20];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset = 1'b1;
    bus.Req = 8'h00;

    // Directed vectors (TURNAROUND=1): reset, no preemption, wrap, mid-op reset.
    tbl[0]  = '{1'b1, 8'hFF, 8'h00, 3'd0, 1'b0};
    tbl[1]  = '{1'b1, 8'hFF, 8'h00, 3'd0, 1'b0};
    tbl[2]  = '{1'b0, 8'hFF, 8'h01, 3'd0, 1'b1};
    tbl[3]  = '{1'b0, 8'h08, 8'h00, 3'd0, 1'b0};
    tbl[4]  = '{1'b0, 8'h08, 8'h00, 3'd0, 1'b0};
    tbl[5]  = '{1'b0, 8'h08, 8'h08, 3'd3, 1'b1};
    tbl[6]  = '{1'b0, 8'h09, 8'h08, 3'd3, 1'b1};
    tbl[7]  = '{1'b0, 8'h09, 8'h08, 3'd3, 1'b1};
    tbl[8]  = '{1'b0, 8'h01, 8'h00, 3'd3, 1'b0};
    tbl[9]  = '{1'b0, 8'h01, 8'h00, 3'd3, 1'b0};
    tbl[10] = '{1'b0, 8'h01, 8'h01, 3'd0, 1'b1};
    tbl[11] = '{1'b0, 8'h00, 8'h00, 3'd0, 1'b0};
    tbl[12] = '{1'b0, 8'h22, 8'h00, 3'd0, 1'b0};
    tbl[13] = '{1'b0, 8'h22, 8'h02, 3'd1, 1'b1};
    tbl[14] = '{1'b0, 8'h20, 8'h00, 3'd1, 1'b0};
    tbl[15] = '{1'b0, 8'h20, 8'h00, 3'd1, 1'b0};
    tbl[16] = '{1'b0, 8'h20, 8'h20, 3'd5, 1'b1};
    tbl[17] = '{1'b0, 8'h20, 8'h20, 3'd5, 1'b1};
    tbl[18] = '{1'b1, 8'h20, 8'h00, 3'd0, 1'b0};
    tbl[19] = '{1'b0, 8'h21, 8'h01, 3'd0, 1'b1};

    for (int i = 0; i < 20; i++) begin
      drive_edge(tbl[i].rst, tbl[i].req);
      check($sformatf("vec%0d_grant", i), bus.Grant, tbl[i].g);
      check($sformatf("vec%0d_sel", i), bus.Sel, tbl[i].s);
      check($sformatf("vec%0d_busvalid", i), bus.BusValid, tbl[i].bv);
      check($sformatf("vec%0d_holdexpired", i), bus.HoldExpired, 0);
    end

    // Rotation with all masters requesting; each owner drops 3 cycles after grant.
    tick(1'b1, 8'hFF);
    for (int g = 0; g < 9; g++) begin
      int waited;
      waited = 0;
      while (!bus.BusValid && waited < 20) begin
        tick(1'b0, 8'hFF);
        waited++;
      end
      check($sformatf("rot%0d_sel", g), bus.Sel, g % 8);
      if (g > 0) check($sformatf("rot%0d_gap", g), waited, TA + 1);
      for (int h = 0; h < 3; h++) tick(1'b0, 8'hFF);
      tick(1'b0, 8'hFF & ~(8'b1 << (g % 8)));
    end

    // Wrap and skip: last owner 6, then masters 1 and 5 request.
    tick(1'b1, 8'h00);
    tick(1'b0, 8'h40);
    check("wrap_own6", bus.Sel, 6);
    tick(1'b0, 8'h00);
    tick(1'b0, 8'h22);
    tick(1'b0, 8'h22);
    check("wrap_sel1", bus.Grant, 8'h02);
    tick(1'b0, 8'h20);
    tick(1'b0, 8'h20);
    tick(1'b0, 8'h20);
    check("wrap_sel5", bus.Sel, 5);

    // Mid-ownership reset of master 5, then master 0 wins first.
    tick(1'b1, 8'h20);
    check("midreset_grant", bus.Grant, 8'h00);
    check("midreset_hexp", bus.HoldExpired, 0);
    tick(1'b0, 8'hFF);
    check("midreset_regrant", bus.Grant, 8'h01);

    // Hold limit with master 2 requesting continuously.
    tick(1'b1, 8'h00);
    begin
      int run, hx, hx_at;
      bit ended;
      run = 0; hx = 0; hx_at = -1; ended = 0;
      for (int i = 0; i < 40; i++) begin
        tick(1'b0, 8'h04);
        if (bus.Grant == 8'h04 && !ended) run++;
        else if (run > 0) ended = 1;
        if (bus.HoldExpired) begin
          hx++;
          if (hx_at < 0) hx_at = i;
        end
      end
`ifdef ARB_TIMEOUT_EN
      check("hold_run", run, MH);
      check("hold_pulse_at", hx_at, MH);
      check("hold_pulses", hx, 2);
`else
      check("hold_run", run, 40);
      check("hold_pulses", hx, 0);
`endif
    end

    // Voluntary drop on the same edge the limit would hit: no HoldExpired.
    tick(1'b1, 8'h00);
    tick(1'b0, 8'h04);
    for (int i = 0; i < MH - 1; i++) tick(1'b0, 8'h04);
    tick(1'b0, 8'h00);
    check("samecycle_grant", bus.Grant, 8'h00);
    check("samecycle_hexp", bus.HoldExpired, 0);

    // Randomized traffic against the reference model.
    begin
      logic [7:0] r;
      r = 8'($urandom);
      for (int i = 0; i < 3000; i++) begin
        if ($urandom_range(0, 7) == 0) r = 8'($urandom);
        tick($urandom_range(0, 299) == 0, r);
      end
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
